// File: rtl/haar_stage_sequencer.sv
// Haar cascade stage sequencer: walks the cascade ROM stage by stage, streams
// classifier words with indices and strobes, and resolves the window verdict.
module haar_stage_sequencer #(
    parameter int unsigned DATA_WIDTH_12       = 12,
    parameter int unsigned ADDR_WIDTH          = 16,
    parameter int unsigned NUM_CLASSIFIERS     = 18,
    parameter int unsigned NUM_STAGE_THRESHOLD = 3,
    parameter int unsigned NUM_STAGES          = 25
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [DATA_WIDTH_12-1:0] rom_data,
    input  logic                     candidate,
    output logic [ADDR_WIDTH-1:0]    rom_addr,
    output logic [DATA_WIDTH_12-1:0] data,
    output logic                     en_copy,
    output logic [DATA_WIDTH_12-1:0] index_classifier,
    output logic [DATA_WIDTH_12-1:0] index_tree,
    output logic [DATA_WIDTH_12-1:0] index_database,
    output logic                     calculate,
    output logic                     end_single_classifier,
    output logic                     end_tree,
    output logic                     end_all_classifier,
    output logic                     end_database,
    output logic                     clear_stage,
    output logic                     busy,
    output logic                     done,
    output logic                     face
);

    localparam int unsigned DW  = DATA_WIDTH_12;
    localparam int unsigned AW  = ADDR_WIDTH;
    localparam int unsigned WCW = (NUM_CLASSIFIERS > 1) ? $clog2(NUM_CLASSIFIERS) : 1;
    localparam int unsigned TCW = (NUM_STAGE_THRESHOLD > 1) ? $clog2(NUM_STAGE_THRESHOLD) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_HEADER, S_HWAIT, S_LOAD, S_CALC,
        S_TRAILER, S_ENDDB, S_EVAL, S_RESULT, S_DONE
    } state_t;

    typedef enum logic [2:0] {K_NONE, K_WORD, K_CALC, K_TRAIL, K_ENDDB} kind_t;

    // Address-side sequencing state
    state_t          state_q, state_d;
    logic [AW-1:0]   rom_addr_q, rom_addr_d;
    logic [WCW-1:0]  word_q, word_d;
    logic [TCW-1:0]  trail_q, trail_d;
    logic [DW-1:0]   tree_q, tree_d;
    logic [DW-1:0]   n_q, n_d;
    logic [1:0]      wait_q, wait_d;
    logic [DW-1:0]   stage_q, stage_d;
    logic            pass_q, pass_d;
    logic            busy_q, busy_d;
    logic            clear_stage_q, clear_stage_d;
    logic            done_q, done_d;
    logic            face_q, face_d;

    // Tag describing the word currently on rom_addr, and its copy aligned with rom_data
    kind_t           kind_a;
    logic            last_tree_a;
    kind_t           kind_b_q;
    logic [WCW-1:0]  idx_b_q;
    logic [DW-1:0]   tree_b_q;
    logic            last_tree_b_q;

    // Output-side registers, aligned with data
    logic [DW-1:0]   data_q, data_d;
    logic            en_copy_q, en_copy_d;
    logic [DW-1:0]   index_classifier_q, index_classifier_d;
    logic [DW-1:0]   index_tree_q, index_tree_d;
    logic            calculate_q, calculate_d;
    logic            end_single_q, end_single_d;
    logic            end_tree_q, end_tree_d;
    logic            end_all_q, end_all_d;
    logic            end_database_q, end_database_d;

    always_comb begin
        state_d       = state_q;
        rom_addr_d    = rom_addr_q;
        word_d        = word_q;
        trail_d       = trail_q;
        tree_d        = tree_q;
        n_d           = n_q;
        wait_d        = wait_q;
        stage_d       = stage_q;
        pass_d        = pass_q;
        busy_d        = busy_q;
        clear_stage_d = 1'b0;
        done_d        = 1'b0;
        face_d        = face_q;
        kind_a        = K_NONE;
        last_tree_a   = (tree_q == n_q - DW'(1));

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    busy_d        = 1'b1;
                    rom_addr_d    = '0;
                    stage_d       = '0;
                    clear_stage_d = 1'b1;
                    face_d        = 1'b0;
                    state_d       = S_HEADER;
                end
            end
            S_HEADER: begin
                rom_addr_d = rom_addr_q + AW'(1);
                word_d     = '0;
                trail_d    = '0;
                tree_d     = '0;
                state_d    = S_HWAIT;
            end
            // Header word is on rom_data now; the next address is held until routed
            S_HWAIT: begin
                n_d     = rom_data;
                state_d = (rom_data == '0) ? S_TRAILER : S_LOAD;
            end
            S_LOAD: begin
                kind_a     = K_WORD;
                rom_addr_d = rom_addr_q + AW'(1);
                if (word_q == WCW'(NUM_CLASSIFIERS - 1)) begin
                    word_d  = '0;
                    state_d = S_CALC;
                end else begin
                    word_d = word_q + WCW'(1);
                end
            end
            S_CALC: begin
                kind_a = K_CALC;
                if (last_tree_a) begin
                    state_d = S_TRAILER;
                end else begin
                    tree_d  = (&tree_q) ? tree_q : tree_q + DW'(1);
                    state_d = S_LOAD;
                end
            end
            S_TRAILER: begin
                kind_a = K_TRAIL;
                if (trail_q == TCW'(NUM_STAGE_THRESHOLD - 1)) begin
                    state_d = S_ENDDB;
                end else begin
                    trail_d    = trail_q + TCW'(1);
                    rom_addr_d = rom_addr_q + AW'(1);
                end
            end
            S_ENDDB: begin
                kind_a  = K_ENDDB;
                wait_d  = '0;
                state_d = S_EVAL;
            end
            // Waits out the output pipeline so candidate is taken 2 cycles after end_database
            S_EVAL: begin
                wait_d = wait_q + 2'd1;
                if (wait_q == 2'd3) begin
                    pass_d  = candidate;
                    state_d = S_RESULT;
                end
            end
            S_RESULT: begin
                if (!pass_q) begin
                    face_d  = 1'b0;
                    state_d = S_DONE;
                end else if (stage_q == DW'(NUM_STAGES - 1)) begin
                    face_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    stage_d       = stage_q + DW'(1);
                    clear_stage_d = 1'b1;
                    rom_addr_d    = rom_addr_q + AW'(1);
                    state_d       = S_HEADER;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        data_d             = rom_data;
        en_copy_d          = (kind_b_q == K_WORD);
        index_classifier_d = (kind_b_q == K_WORD) ? DW'(idx_b_q) : index_classifier_q;
        index_tree_d       = (kind_b_q == K_WORD || kind_b_q == K_CALC) ? tree_b_q : index_tree_q;
        calculate_d        = (kind_b_q == K_CALC);
        end_single_d       = (kind_b_q == K_WORD) && (idx_b_q == WCW'(NUM_CLASSIFIERS - 1));
        end_tree_d         = (kind_b_q == K_CALC) && last_tree_b_q;
        end_all_d          = (kind_b_q == K_TRAIL);
        end_database_d     = (kind_b_q == K_ENDDB);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q            <= S_IDLE;
            rom_addr_q         <= '0;
            word_q             <= '0;
            trail_q            <= '0;
            tree_q             <= '0;
            n_q                <= '0;
            wait_q             <= '0;
            stage_q            <= '0;
            pass_q             <= 1'b0;
            busy_q             <= 1'b0;
            clear_stage_q      <= 1'b0;
            done_q             <= 1'b0;
            face_q             <= 1'b0;
            kind_b_q           <= K_NONE;
            idx_b_q            <= '0;
            tree_b_q           <= '0;
            last_tree_b_q      <= 1'b0;
            data_q             <= '0;
            en_copy_q          <= 1'b0;
            index_classifier_q <= '0;
            index_tree_q       <= '0;
            calculate_q        <= 1'b0;
            end_single_q       <= 1'b0;
            end_tree_q         <= 1'b0;
            end_all_q          <= 1'b0;
            end_database_q     <= 1'b0;
        end else begin
            state_q            <= state_d;
            rom_addr_q         <= rom_addr_d;
            word_q             <= word_d;
            trail_q            <= trail_d;
            tree_q             <= tree_d;
            n_q                <= n_d;
            wait_q             <= wait_d;
            stage_q            <= stage_d;
            pass_q             <= pass_d;
            busy_q             <= busy_d;
            clear_stage_q      <= clear_stage_d;
            done_q             <= done_d;
            face_q             <= face_d;
            kind_b_q           <= kind_a;
            idx_b_q            <= word_q;
            tree_b_q           <= tree_q;
            last_tree_b_q      <= last_tree_a;
            data_q             <= data_d;
            en_copy_q          <= en_copy_d;
            index_classifier_q <= index_classifier_d;
            index_tree_q       <= index_tree_d;
            calculate_q        <= calculate_d;
            end_single_q       <= end_single_d;
            end_tree_q         <= end_tree_d;
            end_all_q          <= end_all_d;
            end_database_q     <= end_database_d;
        end
    end

    assign rom_addr              = rom_addr_q;
    assign data                  = data_q;
    assign en_copy               = en_copy_q;
    assign index_classifier      = index_classifier_q;
    assign index_tree            = index_tree_q;
    assign index_database        = stage_q;
    assign calculate             = calculate_q;
    assign end_single_classifier = end_single_q;
    assign end_tree              = end_tree_q;
    assign end_all_classifier    = end_all_q;
    assign end_database          = end_database_q;
    assign clear_stage           = clear_stage_q;
    assign busy                  = busy_q;
    assign done                  = done_q;
    assign face                  = face_q;

endmodule

// File: doc/haar_stage_sequencer.md
Name: haar_stage_sequencer

Overview:
- Upstream controller for fifo_stage_classifier.
- Walks the Haar cascade database ROM stage by stage and streams classifier words with per-word indices.
- Generates the en_copy / calculate / end_* strobes the classifier consumes.
- Reads back o_candidate after each stage, exits early on rejection, and reports the final face/no-face verdict for the current integral window.

Parameters:
- DATA_WIDTH_12, 12, width of ROM words and all index outputs.
- ADDR_WIDTH, 16, ROM address width.
- NUM_CLASSIFIERS, 18, words per classifier record.
- NUM_STAGE_THRESHOLD, 3, words per stage trailer (threshold, parent, next).
- NUM_STAGES, 25, stages in the cascade.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse, window ready; honoured only in IDLE.
- rom_data  in  DATA_WIDTH_12  ROM read data, valid one cycle after rom_addr.
- candidate  in  1  stage pass flag from classifier.
- rom_addr  out  ADDR_WIDTH  ROM read address.
- data  out  DATA_WIDTH_12  registered copy of rom_data, aligned with strobes.
- en_copy  out  1  data holds a classifier word.
- index_classifier  out  DATA_WIDTH_12  word index 0..NUM_CLASSIFIERS-1 within record.
- index_tree  out  DATA_WIDTH_12  classifier number within current stage.
- index_database  out  DATA_WIDTH_12  current stage number.
- calculate  out  1  one-cycle pulse, evaluate loaded classifier.
- end_single_classifier  out  1  pulse with the last word (index 17) of a record.
- end_tree  out  1  pulse coincident with calculate of the stage's last classifier.
- end_all_classifier  out  1  high for exactly NUM_STAGE_THRESHOLD cycles while data holds trailer words.
- end_database  out  1  one-cycle pulse after last trailer word.
- clear_stage  out  1  one-cycle pulse at each stage start (clears downstream accumulator).
- busy  out  1  high from start accept until done.
- done  out  1  one-cycle pulse, verdict valid.
- face  out  1  verdict, held until next start.

Behaviour:
- Reset:
  - All outputs 0, rom_addr 0, state IDLE.
  - Reset mid-operation aborts immediately; no done pulse.
- Database layout:
  - Address 0 holds stage 0.
  - Each stage record: header word N (classifier count), then N×NUM_CLASSIFIERS words, then NUM_STAGE_THRESHOLD trailer words.
  - Stages are contiguous.
- FSM: IDLE -> HEADER -> LOAD -> CALC -> (LOAD | TRAILER) -> EVAL -> RESULT -> (HEADER | DONE) -> IDLE.
- IDLE:
  - start sets busy=1, rom_addr=0, index_database=0, clear_stage=1 for one cycle.
  - start in any other state is ignored.
- HEADER:
  - Issue header address; capture N one cycle later.
  - N==0: go straight to TRAILER, with no calculate and no end_tree.
- LOAD:
  - Issue 18 consecutive addresses, one per cycle.
  - Data appears on the next cycle with en_copy=1 and index_classifier=0..17 ascending.
  - end_single_classifier is asserted with index 17.
- CALC:
  - calculate pulses exactly one cycle after the en_copy with index 17.
  - No en_copy is asserted in that cycle.
  - The next record's first address issues in the same cycle.
  - Classifier period is therefore 19 cycles; index_tree increments after calculate.
- TRAILER:
  - 3 words are output with end_all_classifier=1 and en_copy=0.
  - end_database pulses the cycle after the third word.
- EVAL/RESULT:
  - candidate is sampled exactly 2 cycles after end_database.
  - candidate=0: face=0, go to DONE.
  - candidate=1 and last stage: face=1, go to DONE.
  - Otherwise: index_database+1, clear_stage pulse, go to HEADER at the next address.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- Exclusivity: en_copy, calculate and end_all_classifier are never high in the same cycle.
- Widths:
  - rom_addr wraps modulo 2^ADDR_WIDTH; no error is flagged.
  - index_tree saturates at 2^DATA_WIDTH_12-1.

Test Plan:
- Reset then idle 10 cycles -> all strobes 0, busy 0, rom_addr 0; start during reset ignored.
- One stage, N=1, words 1..18, trailer 100,0,1, candidate=1, NUM_STAGES=1 -> en_copy indices 0..17 with data 1..18, calculate 1 cycle after word 18, end_tree with it, end_all_classifier 3 cycles with data 100,0,1, end_database, done with face=1.
- Two stages, N=2 and N=3, candidate=1 both -> calculate pulses 19 cycles apart, index_tree 0,1 then 0,1,2, two clear_stage pulses, stage-1 header read at address 2*18+3+1=40, face=1.
- Stage 0 candidate=0, NUM_STAGES=25 -> done after stage 0 only, face=0, no rom_addr beyond stage-0 trailer.
- N=0 header -> no en_copy or calculate, trailer streamed directly, end_database still pulses.
- Reset asserted in the middle of LOAD, then start -> outputs cleared next cycle, no done pulse, fresh run restarts at rom_addr 0 with index_classifier 0.
